// File: rtl/multiplexer_16_to_1_if.sv
// Bus bundle for the registered 16-to-1 word multiplexer: select, the sixteen
// candidate words and the registered result. The master drives the select and
// the data words; the slave (the multiplexer) returns B.
interface multiplexer_16_to_1_if #(
   parameter int unsigned WIDTH = 128
);
   logic [3:0]       sel;
   logic [WIDTH-1:0] A0;
   logic [WIDTH-1:0] A1;
   logic [WIDTH-1:0] A2;
   logic [WIDTH-1:0] A3;
   logic [WIDTH-1:0] A4;
   logic [WIDTH-1:0] A5;
   logic [WIDTH-1:0] A6;
   logic [WIDTH-1:0] A7;
   logic [WIDTH-1:0] A8;
   logic [WIDTH-1:0] A9;
   logic [WIDTH-1:0] A10;
   logic [WIDTH-1:0] A11;
   logic [WIDTH-1:0] A12;
   logic [WIDTH-1:0] A13;
   logic [WIDTH-1:0] A14;
   logic [WIDTH-1:0] A15;
   logic [WIDTH-1:0] B;

   modport master (
      output sel,
      output A0, A1, A2, A3, A4, A5, A6, A7,
      output A8, A9, A10, A11, A12, A13, A14, A15,
      input  B
   );

   modport slave (
      input  sel,
      input  A0, A1, A2, A3, A4, A5, A6, A7,
      input  A8, A9, A10, A11, A12, A13, A14, A15,
      output B
   );
endinterface

// File: rtl/multiplexer_16_to_1.sv
// Registered 16-to-1 word multiplexer. One of sixteen WIDTH-bit words is chosen
// by a 4-bit select and captured in a single output register, so B reflects the
// select/data present at the previous rising edge. Synchronous active-low reset
// clears the register and takes priority over the selection.
module multiplexer_16_to_1 #(
   parameter int unsigned WIDTH = 128
) (
   input  logic                  clk,
   input  logic                  rst_n,
   multiplexer_16_to_1_if.slave  bus
);

   logic [WIDTH-1:0] w_sel_data;
   logic [WIDTH-1:0] r_b;

   // Full 16-way decode of the select; every code maps to exactly one input.
   always_comb begin
      w_sel_data = '0;
      case (bus.sel)
         4'd0:  w_sel_data = bus.A0;
         4'd1:  w_sel_data = bus.A1;
         4'd2:  w_sel_data = bus.A2;
         4'd3:  w_sel_data = bus.A3;
         4'd4:  w_sel_data = bus.A4;
         4'd5:  w_sel_data = bus.A5;
         4'd6:  w_sel_data = bus.A6;
         4'd7:  w_sel_data = bus.A7;
         4'd8:  w_sel_data = bus.A8;
         4'd9:  w_sel_data = bus.A9;
         4'd10: w_sel_data = bus.A10;
         4'd11: w_sel_data = bus.A11;
         4'd12: w_sel_data = bus.A12;
         4'd13: w_sel_data = bus.A13;
         4'd14: w_sel_data = bus.A14;
         4'd15: w_sel_data = bus.A15;
         default: w_sel_data = '0;
      endcase
   end

   // Output register: reset clears it, otherwise capture the selected word.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_b <= '0;
      end else begin
         r_b <= w_sel_data;
      end
   end

   assign bus.B = r_b;

endmodule

// File: tb/tb_multiplexer_16_to_1.sv
// Directed, table-driven bench for the registered 16-to-1 multiplexer.
module tb_multiplexer_16_to_1;

   localparam int unsigned W = 128;

   typedef struct {
      string         name;
      logic          rst_n;
      logic [3:0]    sel;
      logic [W-1:0]  exp;
   } vec_t;

   logic          clk;
   logic          rst_n;
   logic [W-1:0]  a [16];
   logic [W-1:0]  prev_exp;
   int            n_total;
   int            n_pass;
   vec_t          vecs [10];

   multiplexer_16_to_1_if #(.WIDTH(W)) bus ();

   assign bus.A0  = a[0];
   assign bus.A1  = a[1];
   assign bus.A2  = a[2];
   assign bus.A3  = a[3];
   assign bus.A4  = a[4];
   assign bus.A5  = a[5];
   assign bus.A6  = a[6];
   assign bus.A7  = a[7];
   assign bus.A8  = a[8];
   assign bus.A9  = a[9];
   assign bus.A10 = a[10];
   assign bus.A11 = a[11];
   assign bus.A12 = a[12];
   assign bus.A13 = a[13];
   assign bus.A14 = a[14];
   assign bus.A15 = a[15];

   multiplexer_16_to_1 #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_total++;
      if (act !== exp) begin
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end else begin
         n_pass++;
      end
   endtask

   // Inputs are changed 1 time unit after an edge; B must not move until the
   // next edge (no combinational path), then holds the new value after it.
   task automatic step(input string name, input logic r, input logic [3:0] s, input logic [W-1:0] exp);
      rst_n   = r;
      bus.sel = s;
      #1;
      check({name, "_hold"}, bus.B, prev_exp);
      @(posedge clk);
      #1;
      check(name, bus.B, exp);
      prev_exp = exp;
   endtask

   initial begin
      n_total  = 0;
      n_pass   = 0;
      rst_n    = 1'b0;
      bus.sel  = 4'd7;
      for (int i = 0; i < 16; i++) a[i] = W'(i);

      vecs[0] = '{"rst_a",    1'b0, 4'd7,  '0};
      vecs[1] = '{"rst_b",    1'b0, 4'd7,  '0};
      vecs[2] = '{"sel2",     1'b1, 4'd2,  W'(2)};
      vecs[3] = '{"sel5",     1'b1, 4'd5,  W'(5)};
      vecs[4] = '{"sel14",    1'b1, 4'd14, W'(14)};
      vecs[5] = '{"sel0",     1'b1, 4'd0,  W'(0)};
      vecs[6] = '{"sel15",    1'b1, 4'd15, W'(15)};
      vecs[7] = '{"pre_rst5", 1'b1, 4'd5,  W'(5)};
      vecs[8] = '{"mid_rst",  1'b0, 4'd5,  '0};
      vecs[9] = '{"resume5",  1'b1, 4'd5,  W'(5)};

      // First reset edge: B is undefined before it, so only check after.
      @(posedge clk);
      #1;
      check("rst_first", bus.B, '0);
      prev_exp = '0;

      for (int v = 0; v < 10; v++) begin
         step(vecs[v].name, vecs[v].rst_n, vecs[v].sel, vecs[v].exp);
      end

      // Exhaustive sweep with byte-replicated patterns.
      for (int i = 0; i < 16; i++) a[i] = {16{8'(8'hA0 + i)}};
      #1;
      // Selected word (A5) changed with sel held; B still shows the old value.
      check("sweep_pre", bus.B, W'(5));
      for (int k = 0; k < 16; k++) begin
         step($sformatf("sweep%0d", k), 1'b1, 4'(k), {16{8'(8'hA0 + k)}});
      end
      check("sweep_last_AF", bus.B, {16{8'hAF}});

      // Data tracking on sel=9.
      for (int i = 0; i < 16; i++) a[i] = W'(i);
      step("track9", 1'b1, 4'd9, W'(9));
      a[9] = '1;
      step("track_a9_ones", 1'b1, 4'd9, '1);
      a[8] = W'(128'h1234);
      step("track_a8_ignored", 1'b1, 4'd9, '1);
      step("track_a8_ignored2", 1'b1, 4'd9, '1);

      // Wide-bit integrity: MSB and LSB both set.
      a[3] = 128'h8000_0000_0000_0000_0000_0000_0000_0001;
      step("wide_a3", 1'b1, 4'd3, 128'h8000_0000_0000_0000_0000_0000_0000_0001);
      step("switch_a8", 1'b1, 4'd8, W'(128'h1234));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/multiplexer_16_to_1.md
Name: multiplexer_16_to_1

Overview:
- Registered 16-to-1 word multiplexer.
- Selects one of sixteen equal-width data inputs (A0..A15) by a 4-bit select and presents it on B after one clock.
- Used in the AES key-recovery datapath to pick one 128-bit state/key candidate out of sixteen.
- One clock domain; synchronous active-low reset.

Parameters:
- WIDTH, 128, bit width of each data input and of output B.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising clk.
- sel  input  4  select index 0..15; value k selects Ak.
- A0  input  WIDTH  data input 0.
- A1 .. A15  input  WIDTH each  data inputs 1..15, one port per index, same meaning as A0.
- B  output  WIDTH  registered selected word.

Behaviour:
- Single output register B_q of WIDTH bits drives B directly. No combinational path from any input to B.
- On rising clk with rst_n=0:
  - B_q <= 0 (all WIDTH bits).
  - Reset has priority over the select path.
- On rising clk with rst_n=1:
  - B_q <= A[sel], sampled at that edge.
  - sel=0..15 maps one-to-one onto A0..A15.
- Latency: exactly 1 cycle. B reflects sel and A values present at the preceding rising edge.
- Throughput: one selection per cycle. sel and data may change every cycle.
- Full decode: all 16 sel codes are valid; no default/undefined selection.
- Data changes: a change on the currently selected Ak with sel stable appears on B one cycle later. Changes on non-selected inputs have no effect.
- Reset mid-operation: B is 0 on the cycle after the reset edge. Normal selection resumes on the first edge with rst_n=1.
- Power-up before first reset: B is undefined. Reset must be applied before use.
- Width rule: no truncation or extension. B is bit-exact copy of the selected input.
- No enables, no handshake, no internal state beyond B_q.
- Implementation: case/indexed selection over the 16 inputs feeding one register; synthesizable, no latches.

Test Plan:
- Reset: set A0..A15 = 0..15, sel=4'd7, hold rst_n=0 for 2 edges -> B = 128'd0 after each edge. Selection is ignored during reset.
- Basic select: release rst_n, A_i = i for i=0..15 -> after one edge:
  - sel=4'b0010 gives B=128'd2.
  - then sel=4'b0101 gives B=128'd5.
  - then sel=4'b1110 gives B=128'd14.
  - Each value appears exactly one cycle after sel is applied.
- Exhaustive sweep: A_i = {16{8'hA0+i}}; step sel 0..15, one per cycle -> each cycle B equals A of the previous cycle's sel, including sel=15 giving all bytes 8'hAF.
- Data tracking: sel=4'd9 held; change A9 from 128'd9 to all-ones; change A8 to 128'h1234 -> B goes to all-ones one cycle after the A9 change. The A8 change never appears.
- Wide-bit integrity: A3 = 128'h8000_0000_0000_0000_0000_0000_0000_0001, sel=3 -> B identical in MSB and LSB; no truncation.
- Reset mid-stream: sel=5, B=128'd5; assert rst_n=0 for one edge -> B=0. Deassert with sel=5 -> B=128'd5 on the following edge.
